// File: rtl/histogram_cdf_pkg.sv
// rtl/histogram_cdf_pkg.sv - shared constants and state encoding for the CDF stage
package histogram_cdf_pkg;

  localparam int HIST_BINS   = 256;
  localparam int HIST_ADDR_W = 8;
  localparam int HIST_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } cdf_state_e;

endpackage

// File: rtl/histogram_cdf_if.sv
// rtl/histogram_cdf_if.sv - histogram read port and CDF write port bundle
interface histogram_cdf_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] arg_0_raddr_0;
  logic [DATA_WIDTH-1:0] arg_0_rdata_0;
  logic [ADDR_WIDTH-1:0] arg_1_waddr_0;
  logic [DATA_WIDTH-1:0] arg_1_wdata_0;
  logic                  arg_1_wen_0;

  // master is the CDF block, slave is the memory side
  modport master (
    output arg_0_raddr_0,
    input  arg_0_rdata_0,
    output arg_1_waddr_0,
    output arg_1_wdata_0,
    output arg_1_wen_0
  );

  modport slave (
    input  arg_0_raddr_0,
    output arg_0_rdata_0,
    input  arg_1_waddr_0,
    input  arg_1_wdata_0,
    input  arg_1_wen_0
  );

endinterface

// File: rtl/histogram_cdf_cdf_accum.sv
// rtl/histogram_cdf_cdf_accum.sv - running-sum register with sticky carry-out flag
module histogram_cdf_cdf_accum #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  add_en_i,
  input  logic [DATA_WIDTH-1:0] addend_i,
  output logic [DATA_WIDTH-1:0] sum_o,
  output logic [DATA_WIDTH-1:0] acc_o,
  output logic                  overflow_o
);

  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH:0]   wide_sum;

  // one extra bit captures the carry that marks a wrapped sum
  assign wide_sum = {1'b0, acc_q} + {1'b0, addend_i};
  assign sum_o    = wide_sum[DATA_WIDTH-1:0];

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (add_en_i) begin
      acc_d = sum_o;
      ovf_d = ovf_q | wide_sum[DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_o      = acc_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/histogram_cdf.sv
// rtl/histogram_cdf.sv - reads histogram bins in order and writes their prefix sum
module histogram_cdf
  import histogram_cdf_pkg::*;
#(
  parameter int NUM_BINS   = HIST_BINS,
  parameter int ADDR_WIDTH = HIST_ADDR_W,
  parameter int DATA_WIDTH = HIST_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  valid,
  histogram_cdf_if.master       mem,
  output logic [DATA_WIDTH-1:0] total,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_BINS - 1);

  cdf_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic                  launch;
  logic                  issue;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (rd_idx_q == LAST_IDX) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  if (start) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid  = (state_q == ST_DONE);
    launch = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    issue  = (state_q == ST_RUN);
  end

  // pend_q marks that the read data arriving this cycle belongs to pend_addr_q
  always_comb begin
    rd_idx_d    = rd_idx_q;
    pend_d      = issue;
    pend_addr_d = pend_addr_q;
    if (launch) begin
      rd_idx_d = '0;
    end else if (issue) begin
      rd_idx_d = rd_idx_q + ADDR_WIDTH'(1);
    end
    if (issue) begin
      pend_addr_d = rd_idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_idx_q    <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      rd_idx_q    <= rd_idx_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  histogram_cdf_cdf_accum #(
    .DATA_WIDTH (DATA_WIDTH)
  ) cdf_accum (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (launch),
    .add_en_i   (pend_q),
    .addend_i   (mem.arg_0_rdata_0),
    .sum_o      (sum),
    .acc_o      (acc),
    .overflow_o (overflow)
  );

  assign mem.arg_0_raddr_0 = rd_idx_q;
  assign mem.arg_1_wen_0   = pend_q;
  assign mem.arg_1_waddr_0 = pend_addr_q;
  assign mem.arg_1_wdata_0 = pend_q ? sum : '0;
  assign total             = acc;

endmodule
